ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Control stage placed directly upstream of the team's simple dual-port RAM (synchronous write, registered read).
- Turns that RAM into a first-in first-out queue by generating its write enable, write address and read address.
- Provides push/pop handshakes with full, empty and occupancy status.
- Forwards the RAM's registered read data to the consumer with a matching valid strobe.

Parameters:
- DATA_WIDTH, 8, width of each stored word; must match the RAM's DATA_WIDTH.
- ADDR_WIDTH, 3, RAM address width; FIFO depth = 2**ADDR_WIDTH (default 8 entries).

Ports:
- clk  input  1  single clock, rising edge; same clock as the RAM.
- rst  input  1  synchronous, active-high reset.
- push  input  1  request to write din this cycle.
- din  input  DATA_WIDTH  data to enqueue.
- pop  input  1  request to dequeue the head entry this cycle.
- dout  output  DATA_WIDTH  dequeued word; equals ram_q.
- dout_valid  output  1  dout holds the word popped in the previous cycle.
- full  output  1  count == 2**ADDR_WIDTH.
- empty  output  1  count == 0.
- count  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- wr_err  output  1  one-cycle pulse: push rejected (overflow).
- rd_err  output  1  one-cycle pulse: pop rejected (underflow).
- ram_we  output  1  to RAM we.
- ram_wdata  output  DATA_WIDTH  to RAM data.
- ram_waddr  output  ADDR_WIDTH  to RAM write_addr.
- ram_raddr  output  ADDR_WIDTH  to RAM read_addr.
- ram_q  input  DATA_WIDTH  from RAM q.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled only at the rising edge of clk.
- Reset values: wptr=0, rptr=0, count=0, empty=1, full=0, dout_valid=0, wr_err=0, rd_err=0.
  - RAM contents are not cleared; the FIFO is logically empty after reset, whatever the RAM holds from its init file.
  - A reset asserted mid-operation discards all queued data and any pending dout_valid on the next edge.
- Pointers: wptr and rptr are ADDR_WIDTH-bit registers that wrap naturally from 2**ADDR_WIDTH-1 to 0. Full and empty are distinguished by count, not by the pointers.
- Acceptance rules (combinational in the request cycle):
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok). Push while full is accepted only together with an accepted pop.
- Write path (combinational): ram_we = push_ok, ram_wdata = din, ram_waddr = wptr.
- Read address: ram_raddr = rptr, driven continuously.
- Edge updates:
  - push_ok: wptr += 1.
  - pop_ok: rptr += 1.
  - count: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- Read latency:
  - The RAM registers q at the same edge that accepts the pop, so the popped word appears on ram_q in the following cycle.
  - dout_valid is registered from pop_ok, giving 1-cycle pop-to-data latency.
  - dout = ram_q, combinational.
  - dout is don't-care while dout_valid=0.
- Simultaneous push/pop when full (wptr==rptr): the RAM reads before it writes, so the old head is returned and the new word lands in the freed slot. count stays at 2**ADDR_WIDTH.
- Simultaneous push/pop when empty: the pop is rejected (rd_err=1), the push is accepted, count becomes 1, dout_valid=0 next cycle. No write-to-read bypass.
- Error pulses:
  - wr_err is registered: 1 for exactly one cycle after a rejected push.
  - rd_err is registered: 1 for exactly one cycle after a rejected pop.
  - Rejected requests change no state.
- Back-to-back pops: one word per cycle; dout_valid stays high continuously.
- Status outputs: full and empty are decoded from registered count, so they are glitch-free and updated one edge after the causing transfer.

Test Plan:
- Reset, then hold push=pop=0 for 3 cycles -> empty=1, full=0, count=0, dout_valid=0, ram_we=0 throughout.
- Push 0x11,0x22,0x33 in consecutive cycles, then pop three times -> count steps 1,2,3 then 2,1,0. dout_valid is high in the 3 cycles after each pop, with dout 0x11,0x22,0x33 in order.
- Push 8 words 0xA0..0xA7 -> full=1, count=8. A 9th push gives wr_err=1 for one cycle and count stays 8. Popping all 8 returns 0xA0..0xA7, then empty=1.
- Fill to 8, then push 0xB0 together with pop in the same cycle -> next cycle dout=0xA0 with dout_valid=1, count=8, and no wr_err. Later pops end with 0xB0 after 0xA7 (wrap-around checked).
- Pop while empty together with push 0x5C -> rd_err=1 for one cycle, dout_valid=0, count=1. A following pop returns 0x5C.
- Push 4 words, assert rst for one cycle alongside a pop -> count=0, empty=1, dout_valid=0 after the edge. The next push/pop returns the newly pushed value, not stale data.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO control stage for a simple dual-port RAM (synchronous write, registered read).
// Generates the RAM write/read controls and forwards the registered read data with a valid strobe.
module ram_fifo_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  wr_err,
   output logic                  rd_err,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   localparam logic [ADDR_WIDTH-1:0] PtrOne = 1;
   localparam logic [ADDR_WIDTH:0]   CntOne = 1;

   logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  dout_valid_q, wr_err_q, rd_err_q;
   logic                  push_ok, pop_ok;

   // count never exceeds the depth, so its MSB alone marks full
   assign full    = count_q[ADDR_WIDTH];
   assign empty   = (count_q == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   assign ram_we     = push_ok;
   assign ram_wdata  = din;
   assign ram_waddr  = wptr_q;
   assign ram_raddr  = rptr_q;
   assign dout       = ram_q;
   assign dout_valid = dout_valid_q;
   assign count      = count_q;
   assign wr_err     = wr_err_q;
   assign rd_err     = rd_err_q;

   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         dout_valid_q <= 1'b0;
         wr_err_q     <= 1'b0;
         rd_err_q     <= 1'b0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + PtrOne;
         if (pop_ok)  rptr_q <= rptr_q + PtrOne;
         count_q      <= count_d;
         dout_valid_q <= pop_ok;
         wr_err_q     <= push & ~push_ok;
         rd_err_q     <= pop & ~pop_ok;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural read-before-write dual-port RAM.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst, push, pop;
   logic [7:0] din, dout, ram_wdata, ram_q;
   logic       dout_valid, full, empty, wr_err, rd_err, ram_we;
   logic [3:0] count;
   logic [2:0] ram_waddr, ram_raddr;
   logic [7:0] mem [8];
   int         passed = 0;
   int         total = 0;

   always #5 clk = ~clk;

   // RAM model: registered read sees the old contents on a same-address write
   always @(posedge clk) begin
      ram_q <= mem[ram_raddr];
      if (ram_we) mem[ram_waddr] <= ram_wdata;
   end

   ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop), .dout(dout),
      .dout_valid(dout_valid), .full(full), .empty(empty), .count(count),
      .wr_err(wr_err), .rd_err(rd_err), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_q(ram_q)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1; push = 1'b0; pop = 1'b0; din = 8'h00;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else passed++;
         total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passed++;
         total++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
         total++; if (dout_valid !== 1'b0) $display("FAIL reset_dv: got %b want 0", dout_valid); else passed++;
         total++; if (ram_we !== 1'b0) $display("FAIL reset_we: got %b want 0", ram_we); else passed++;
      end
   endtask

   task automatic test_basic();
      logic [7:0] vals [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         push = 1'b1; din = vals[i];
         #1;
         total++; if (ram_waddr !== 3'(i)) $display("FAIL basic_waddr: got %0d want %0d", ram_waddr, i); else passed++;
         tick();
         total++; if (count !== 4'(i + 1)) $display("FAIL basic_push_count: got %0d want %0d", count, i + 1); else passed++;
      end
      push = 1'b0; pop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (dout_valid !== 1'b1) $display("FAIL basic_dv: got %b want 1", dout_valid); else passed++;
         total++; if (dout !== vals[i]) $display("FAIL basic_dout: got %h want %h", dout, vals[i]); else passed++;
         total++; if (count !== 4'(2 - i)) $display("FAIL basic_pop_count: got %0d want %0d", count, 2 - i); else passed++;
      end
      pop = 1'b0;
      tick();
      total++; if (dout_valid !== 1'b0) $display("FAIL basic_dv_low: got %b want 0", dout_valid); else passed++;
      total++; if (empty !== 1'b1) $display("FAIL basic_empty: got %b want 1", empty); else passed++;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) begin
         push = 1'b1; din = 8'hA0 + 8'(i);
         tick();
      end
      total++; if (full !== 1'b1) $display("FAIL ovf_full: got %b want 1", full); else passed++;
      total++; if (count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", count); else passed++;
      din = 8'hFF;
      #1;
      total++; if (ram_we !== 1'b0) $display("FAIL ovf_we: got %b want 0", ram_we); else passed++;
      tick();
      push = 1'b0;
      total++; if (wr_err !== 1'b1) $display("FAIL ovf_wr_err: got %b want 1", wr_err); else passed++;
      total++; if (count !== 4'd8) $display("FAIL ovf_count_hold: got %0d want 8", count); else passed++;
      tick();
      total++; if (wr_err !== 1'b0) $display("FAIL ovf_wr_err_pulse: got %b want 0", wr_err); else passed++;
      pop = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++; if (dout_valid !== 1'b1 || dout !== 8'hA0 + 8'(i))
            $display("FAIL ovf_dout: got %b/%h want 1/%h", dout_valid, dout, 8'hA0 + 8'(i));
         else passed++;
      end
      pop = 1'b0;
      tick();
      total++; if (empty !== 1'b1) $display("FAIL ovf_empty: got %b want 1", empty); else passed++;
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp;
      for (int i = 0; i < 8; i++) begin
         push = 1'b1; din = 8'hA0 + 8'(i);
         tick();
      end
      din = 8'hB0; pop = 1'b1;
      #1;
      total++; if (ram_we !== 1'b1) $display("FAIL fpp_we: got %b want 1", ram_we); else passed++;
      tick();
      push = 1'b0;
      total++; if (dout_valid !== 1'b1 || dout !== 8'hA0)
         $display("FAIL fpp_dout: got %b/%h want 1/a0", dout_valid, dout);
      else passed++;
      total++; if (count !== 4'd8) $display("FAIL fpp_count: got %0d want 8", count); else passed++;
      total++; if (wr_err !== 1'b0) $display("FAIL fpp_wr_err: got %b want 0", wr_err); else passed++;
      for (int i = 1; i < 9; i++) begin
         exp = (i == 8) ? 8'hB0 : 8'hA0 + 8'(i);
         tick();
         total++; if (dout_valid !== 1'b1 || dout !== exp)
            $display("FAIL fpp_drain: got %b/%h want 1/%h", dout_valid, dout, exp);
         else passed++;
      end
      pop = 1'b0;
      tick();
      total++; if (empty !== 1'b1) $display("FAIL fpp_empty: got %b want 1", empty); else passed++;
   endtask

   task automatic test_empty_push_pop();
      push = 1'b1; pop = 1'b1; din = 8'h5C;
      tick();
      push = 1'b0; pop = 1'b0;
      total++; if (rd_err !== 1'b1) $display("FAIL epp_rd_err: got %b want 1", rd_err); else passed++;
      total++; if (dout_valid !== 1'b0) $display("FAIL epp_dv: got %b want 0", dout_valid); else passed++;
      total++; if (count !== 4'd1) $display("FAIL epp_count: got %0d want 1", count); else passed++;
      total++; if (wr_err !== 1'b0) $display("FAIL epp_wr_err: got %b want 0", wr_err); else passed++;
      tick();
      total++; if (rd_err !== 1'b0) $display("FAIL epp_rd_err_pulse: got %b want 0", rd_err); else passed++;
      pop = 1'b1;
      tick();
      pop = 1'b0;
      total++; if (dout_valid !== 1'b1 || dout !== 8'h5C)
         $display("FAIL epp_dout: got %b/%h want 1/5c", dout_valid, dout);
      else passed++;
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         push = 1'b1; din = 8'hC0 + 8'(i);
         tick();
      end
      push = 1'b0; pop = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; pop = 1'b0;
      total++; if (count !== 4'd0) $display("FAIL rst_mid_count: got %0d want 0", count); else passed++;
      total++; if (empty !== 1'b1) $display("FAIL rst_mid_empty: got %b want 1", empty); else passed++;
      total++; if (dout_valid !== 1'b0) $display("FAIL rst_mid_dv: got %b want 0", dout_valid); else passed++;
      total++; if (ram_raddr !== 3'd0) $display("FAIL rst_mid_raddr: got %0d want 0", ram_raddr); else passed++;
      push = 1'b1; din = 8'hD5;
      tick();
      push = 1'b0; pop = 1'b1;
      tick();
      pop = 1'b0;
      total++; if (dout_valid !== 1'b1 || dout !== 8'hD5)
         $display("FAIL rst_mid_dout: got %b/%h want 1/d5", dout_valid, dout);
      else passed++;
      tick();
      total++; if (empty !== 1'b1) $display("FAIL rst_mid_final_empty: got %b want 1", empty); else passed++;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'hEE;
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_empty_push_pop();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
